vga_scan_gen: RTL and testbench
===============================

VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock, 50 MHz.
REQ-002 SHALL have port reset, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port hsync, output, 1 bit: horizontal sync, active-low.
REQ-004 SHALL have port vsync, output, 1 bit: vertical sync, active-low.
REQ-005 SHALL have port video_on, output, 1 bit: high while the scan is in the 640x480 visible area.
REQ-006 SHALL have port p_tick, output, 1 bit: 25 MHz pixel enable, one clk wide.
REQ-007 SHALL have port pix_x, output, 10 bits: current horizontal scan count, 0..799.
REQ-008 SHALL have port pix_y, output, 10 bits: current vertical scan count, 0..524.
REQ-009 SHALL have port refr_tick, output, 1 bit: one-clk frame-refresh pulse.

Function
REQ-010 SHALL toggle a 1-bit divider every clk; p_tick SHALL be high on clk cycles where the divider is 1.
REQ-011 SHALL increment pix_x on each clk edge where p_tick=1; at 799 it SHALL wrap to 0.
REQ-012 SHALL increment pix_y only when pix_x wraps 799->0; at 524 it SHALL wrap to 0.
REQ-013 Line timing: 640 display, 16 front porch, 96 sync, 48 back porch = 800 pixels.
REQ-014 Frame timing: 480 display, 10 front porch, 2 sync, 33 back porch = 525 lines.
REQ-015 hsync SHALL be a register, low exactly while pix_x is in 656..751, updated on the same edge as pix_x.
REQ-016 vsync SHALL be a register, low exactly while pix_y is in 490..491, updated on the same edge as pix_y.
REQ-017 video_on SHALL be combinational: (pix_x<640) && (pix_y<480).
REQ-018 refr_tick SHALL be combinational: (pix_y==481) && (pix_x==0) && p_tick, so it is high for exactly one clk per frame.
REQ-019 Counters SHALL use 10-bit unsigned arithmetic; no value outside the stated ranges SHALL ever appear.
REQ-020 Counter wrap and sync updates SHALL occur on the same p_tick edge, with no intermediate value at the frame corner (799,524)->(0,0).

Reset
REQ-021 While reset=0, the block SHALL hold divider=0, pix_x=0, pix_y=0, hsync=1 and vsync=1; consequently p_tick=0, video_on=1 and refr_tick=0.
REQ-022 Reset assertion mid-frame SHALL take effect immediately, without waiting for clk.
REQ-023 After reset release, the first p_tick SHALL occur on the second clk edge.

Configuration
REQ-024 With macro VGA_FRAME_CNT_EN defined, the block SHALL add output frame_cnt, 8 bits, reset to 0, incremented on each refr_tick and wrapping 255->0.
REQ-025 Without VGA_FRAME_CNT_EN, the frame_cnt port and its register SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-026 A shared package vga_pkg SHALL hold all timing constants: H_DISP, H_FP, H_SYNC, H_BP, H_TOTAL, V_DISP, V_FP, V_SYNC, V_BP, V_TOTAL, and the REFR_LINE=481 refresh line.
REQ-027 One sub-module, scan_counter, SHALL be used: a parameterised modulo-M counter with enable and wrap output, instantiated once for x and once for y.
REQ-028 Consumers (renderers) SHALL use pix_x, pix_y, video_on and refr_tick from this block only; they SHALL NOT duplicate the timing logic.

Verification
REQ-029 Reset scenario: hold reset=0 for 3 clk, then release -> pix_x=0, pix_y=0, hsync=1, vsync=1, video_on=1; first p_tick on the 2nd clk edge; pix_x=1 after 2 clk.
REQ-030 Line scenario: run one line -> 1600 clk between successive pix_x 0 events; hsync low for 192 clk, starting at pix_x=656; video_on falls at pix_x=640.
REQ-031 Frame scenario: run one frame -> 840000 clk per frame; vsync low for exactly 2 lines (pix_y 490, 491); refr_tick pulses exactly once, at (0,481).
REQ-032 Wrap scenario: observe the frame corner -> (799,524) is followed by (0,0) on the next p_tick; no other value appears; video_on rises at (0,0).
REQ-033 Reset mid-frame scenario: assert reset at (300,200) between clk edges -> outputs return to their reset values asynchronously; counting restarts from (0,0) after release.
REQ-034 Frame-counter scenario (VGA_FRAME_CNT_EN only): run 256 frames -> frame_cnt counts 0..255, then returns to 0 on the 256th refr_tick.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg -- shared VGA 640x480@60 timing constants and helpers.
// Everything that knows the raster geometry lives here; the scan generator
// takes its defaults from these values so renderers never restate them.
package vga_pkg;

  localparam int CNT_W     = 10;

  localparam int H_DISP    = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_DISP + H_FP + H_SYNC + H_BP;   // 800

  localparam int V_DISP    = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_DISP + V_FP + V_SYNC + V_BP;   // 525

  // Line on which the once-per-frame refresh pulse fires (in front porch).
  localparam int REFR_LINE = 481;

  typedef struct packed {
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } scan_pos_t;

  // True when v lies in [lo, lo+len).
  function automatic logic in_window(logic [CNT_W-1:0] v, int lo, int len);
    int vi;
    vi = int'(v);
    return (vi >= lo) && (vi < lo + len);
  endfunction

endpackage

// File: rtl/scan_counter.sv
// scan_counter -- modulo-M up counter with enable.
// Ports:
//   clk, reset   clock, async active-low reset (count -> 0)
//   en           advance by one on this edge
//   cnt          current count, 0..M-1
//   cnt_nxt      value cnt takes on the next edge (lets callers register
//                decodes in step with the count)
//   wrap         en && cnt==M-1: the count returns to 0 on this edge
module scan_counter
  import vga_pkg::*;
#(
  parameter int M = H_TOTAL,
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(M - 1);

  assign wrap = en && (cnt == LAST);

  always_comb begin
    cnt_nxt = cnt;
    if (en) cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else        cnt <= cnt_nxt;

endmodule

// File: rtl/vga_scan_gen.sv
// vga_scan_gen -- VGA raster scan generator (640x480, 25 MHz pixel from 50 MHz).
// Ports:
//   clk          50 MHz system clock
//   reset        async active-low reset
//   hsync/vsync  registered active-low syncs, aligned with pix_x/pix_y
//   video_on     scan position inside the visible area
//   p_tick       pixel enable, one clk wide, every other clk
//   pix_x/pix_y  current scan position
//   refr_tick    one clk per frame at (0, REFR_LINE)
//   frame_cnt    8-bit frame counter, only when VGA_FRAME_CNT_EN is defined
// Timing parameters default to vga_pkg and only exist so a shrunken raster
// can be elaborated; real builds leave them alone.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int HDISP = H_DISP,
  parameter int HFP   = H_FP,
  parameter int HSYNC = H_SYNC,
  parameter int HBP   = H_BP,
  parameter int VDISP = V_DISP,
  parameter int VFP   = V_FP,
  parameter int VSYNC = V_SYNC,
  parameter int VBP   = V_BP,
  parameter int REFR  = REFR_LINE
) (
  input  logic             clk,
  input  logic             reset,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             p_tick,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
`ifdef VGA_FRAME_CNT_EN
  output logic [7:0]       frame_cnt,
`endif
  output logic             refr_tick
);

  localparam int HTOT = HDISP + HFP + HSYNC + HBP;
  localparam int VTOT = VDISP + VFP + VSYNC + VBP;

  localparam logic [CNT_W-1:0] HDISP_L = CNT_W'(HDISP);
  localparam logic [CNT_W-1:0] VDISP_L = CNT_W'(VDISP);
  localparam logic [CNT_W-1:0] REFR_L  = CNT_W'(REFR);

  logic             div;
  logic [CNT_W-1:0] x, y, x_nxt, y_nxt;
  logic             x_wrap;
  logic             y_wrap_unused;   // end-of-frame is not needed downstream
  scan_pos_t        nxt;

  // 1-bit divider: p_tick high on every second clk, first one on the
  // second edge after reset release.
  always_ff @(posedge clk or negedge reset)
    if (!reset) div <= 1'b0;
    else        div <= ~div;

  assign p_tick = div;

  scan_counter #(.M(HTOT), .W(CNT_W)) u_x (
    .clk     (clk),
    .reset   (reset),
    .en      (p_tick),
    .cnt     (x),
    .cnt_nxt (x_nxt),
    .wrap    (x_wrap)
  );

  // y advances only on the x wrap, so the corner (799,524)->(0,0) moves
  // both counters on the same edge with no intermediate value.
  scan_counter #(.M(VTOT), .W(CNT_W)) u_y (
    .clk     (clk),
    .reset   (reset),
    .en      (x_wrap),
    .cnt     (y),
    .cnt_nxt (y_nxt),
    .wrap    (y_wrap_unused)
  );

  assign nxt = '{x: x_nxt, y: y_nxt};

  // Syncs are decoded from the next position so the registered value lines
  // up with the counters rather than trailing them by a pixel.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (p_tick) begin
      hsync <= ~in_window(nxt.x, HDISP + HFP, HSYNC);
      vsync <= ~in_window(nxt.y, VDISP + VFP, VSYNC);
    end

  assign pix_x     = x;
  assign pix_y     = y;
  assign video_on  = (x < HDISP_L) && (y < VDISP_L);
  // (0,REFR) lasts two clk; gating with p_tick keeps the pulse one clk wide.
  assign refr_tick = (y == REFR_L) && (x == '0) && p_tick;

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset)         frame_cnt <= 8'd0;
    else if (refr_tick) frame_cnt <= frame_cnt + 8'd1;
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen -- checks vga_scan_gen against an arithmetic raster model.
// Two instances: the full 800x525 raster (reset and line timing) and a
// shrunken 10x11 raster so whole frames fit in a short run.
module tb_vga_scan_gen;

  // shrunken raster: H 6/1/2/1 = 10, V 6/2/2/1 = 11, refresh line 7
  localparam int SHD = 6, SHF = 1, SHS = 2, SHB = 1, SHT = 10;
  localparam int SVD = 6, SVF = 2, SVS = 2, SVB = 1, SVT = 11, SRL = 7;
  localparam int SFRAME = 2 * SHT * SVT;   // clk per small frame

  logic clk = 1'b0;
  logic rst_f = 1'b0, rst_s = 1'b0;

  logic       f_h, f_v, f_von, f_pt, f_rt;
  logic [9:0] f_x, f_y;
  logic       s_h, s_v, s_von, s_pt, s_rt;
  logic [9:0] s_x, s_y;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] f_fc, s_fc;
`endif

  int checks = 0;
  int fails  = 0;

  always #10 clk = ~clk;

  vga_scan_gen dut_full (
    .clk(clk), .reset(rst_f), .hsync(f_h), .vsync(f_v), .video_on(f_von),
    .p_tick(f_pt), .pix_x(f_x), .pix_y(f_y),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt(f_fc),
`endif
    .refr_tick(f_rt)
  );

  vga_scan_gen #(
    .HDISP(SHD), .HFP(SHF), .HSYNC(SHS), .HBP(SHB),
    .VDISP(SVD), .VFP(SVF), .VSYNC(SVS), .VBP(SVB), .REFR(SRL)
  ) dut_small (
    .clk(clk), .reset(rst_s), .hsync(s_h), .vsync(s_v), .video_on(s_von),
    .p_tick(s_pt), .pix_x(s_x), .pix_y(s_y),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt(s_fc),
`endif
    .refr_tick(s_rt)
  );

  // Model: n = clk edges since reset release. Pixel index = n/2 modulo the
  // frame size; everything else follows from the raster definition.
  // Packing: {x[9:0], y[9:0], hsync, vsync, video_on, p_tick, refr_tick}
  function automatic logic [24:0] model(int n, int ht, int vt, int hd, int hf,
                                        int hs, int vd, int vf, int vs, int rl);
    int idx, x, y;
    logic pt, h, v, von, rt;
    idx = (n / 2) % (ht * vt);
    x   = idx % ht;
    y   = idx / ht;
    pt  = (n % 2) == 1;
    h   = !(x >= hd + hf && x < hd + hf + hs);
    v   = !(y >= vd + vf && y < vd + vf + vs);
    von = (x < hd) && (y < vd);
    rt  = (y == rl) && (x == 0) && pt;
    return {10'(x), 10'(y), h, v, von, pt, rt};
  endfunction

  function automatic logic [24:0] m_full(int n);
    return model(n, 800, 525, 640, 16, 96, 480, 10, 2, 481);
  endfunction

  function automatic logic [24:0] m_small(int n);
    return model(n, SHT, SVT, SHD, SHF, SHS, SVD, SVF, SVS, SRL);
  endfunction

  int n_f, n_s;
  always @(posedge clk or negedge rst_f)
    if (!rst_f) n_f <= 0; else n_f <= n_f + 1;
  always @(posedge clk or negedge rst_s)
    if (!rst_s) n_s <= 0; else n_s <= n_s + 1;

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] fc_s;
  always @(posedge clk or negedge rst_s)
    if (!rst_s) fc_s <= 8'd0;
    else if (m_small(n_s)[0]) fc_s <= fc_s + 8'd1;
`endif

  wire [24:0] act_f = {f_x, f_y, f_h, f_v, f_von, f_pt, f_rt};
  wire [24:0] act_s = {s_x, s_y, s_h, s_v, s_von, s_pt, s_rt};
  localparam logic [24:0] RST_VEC = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic test_reset();
    rst_f = 1'b0; rst_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (act_f !== RST_VEC) begin
      fails++; $display("FAIL reset_full: got %h expected %h", act_f, RST_VEC);
    end
    checks++;
    if (act_s !== RST_VEC) begin
      fails++; $display("FAIL reset_small: got %h expected %h", act_s, RST_VEC);
    end
    @(negedge clk);
    rst_f = 1'b1; rst_s = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (f_pt !== 1'b1 || f_x !== 10'd0) begin
      fails++; $display("FAIL first_edge: got p_tick=%b x=%0d expected p_tick=1 x=0", f_pt, f_x);
    end
    @(posedge clk); #1;
    checks++;
    if (f_pt !== 1'b0 || f_x !== 10'd1 || f_y !== 10'd0) begin
      fails++; $display("FAIL second_edge: got p_tick=%b x=%0d y=%0d expected 0 1 0", f_pt, f_x, f_y);
    end
  endtask

  task automatic test_line();
    int c = 0, last0 = -1, hfall = -1;
    logic [9:0] px;
    logic ph, pv;
    logic [24:0] e;
    @(negedge clk);
    px = f_x; ph = f_h; pv = f_von;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk); c++;
      e = m_full(n_f);
      checks++;
      if (act_f !== e) begin
        fails++; $display("FAIL line_model n=%0d: got %h expected %h", n_f, act_f, e);
      end
      if (f_x == 10'd0 && px != 10'd0) begin
        if (last0 >= 0) begin
          checks++;
          if (c - last0 !== 1600) begin
            fails++; $display("FAIL line_period: got %0d clk expected 1600", c - last0);
          end
        end
        last0 = c;
      end
      if (!f_h && ph) begin
        hfall = c;
        checks++;
        if (f_x !== 10'd656) begin
          fails++; $display("FAIL hsync_start: got x=%0d expected 656", f_x);
        end
      end
      if (f_h && !ph && hfall >= 0) begin
        checks++;
        if (c - hfall !== 192) begin
          fails++; $display("FAIL hsync_width: got %0d clk expected 192", c - hfall);
        end
      end
      if (!f_von && pv) begin
        checks++;
        if (f_x !== 10'd640) begin
          fails++; $display("FAIL video_fall: got x=%0d expected 640", f_x);
        end
      end
      px = f_x; ph = f_h; pv = f_von;
    end
  endtask

  task automatic test_frame();
    int c = 0, last_rt = -1, vfall = -1, pulses = 0;
    logic pvs;
    logic [24:0] e;
    @(negedge clk);
    pvs = s_v;
    for (int i = 0; i < 3 * SFRAME; i++) begin
      @(negedge clk); c++;
      e = m_small(n_s);
      checks++;
      if (act_s !== e) begin
        fails++; $display("FAIL frame_model n=%0d: got %h expected %h", n_s, act_s, e);
      end
      if (s_rt) begin
        pulses++;
        checks++;
        if (s_x !== 10'd0 || s_y !== 10'(SRL)) begin
          fails++; $display("FAIL refr_pos: got (%0d,%0d) expected (0,%0d)", s_x, s_y, SRL);
        end
        if (last_rt >= 0) begin
          checks++;
          if (c - last_rt !== SFRAME) begin
            fails++; $display("FAIL frame_period: got %0d expected %0d", c - last_rt, SFRAME);
          end
        end
        last_rt = c;
      end
      if (!s_v && pvs) begin
        vfall = c;
        checks++;
        if (s_y !== 10'(SVD + SVF) || s_x !== 10'd0) begin
          fails++; $display("FAIL vsync_start: got (%0d,%0d) expected (0,%0d)", s_x, s_y, SVD + SVF);
        end
      end
      if (s_v && !pvs && vfall >= 0) begin
        checks++;
        if (c - vfall !== 2 * SHT * SVS) begin
          fails++; $display("FAIL vsync_width: got %0d expected %0d", c - vfall, 2 * SHT * SVS);
        end
      end
      pvs = s_v;
    end
    checks++;
    if (pulses !== 3) begin
      fails++; $display("FAIL refr_count: got %0d expected 3", pulses);
    end
  endtask

  task automatic test_wrap();
    bit found = 0;
    for (int i = 0; i < 2 * SFRAME && !found; i++) begin
      @(negedge clk);
      if (s_pt && s_x == 10'(SHT - 1) && s_y == 10'(SVT - 1)) found = 1;
    end
    checks++;
    if (!found) begin
      fails++; $display("FAIL wrap_timeout: got no corner expected (%0d,%0d)", SHT - 1, SVT - 1);
    end else begin
      @(negedge clk);
      checks++;
      if (s_x !== 10'd0 || s_y !== 10'd0 || s_von !== 1'b1 || s_pt !== 1'b0) begin
        fails++; $display("FAIL wrap_corner: got (%0d,%0d) von=%b pt=%b expected (0,0) von=1 pt=0",
                          s_x, s_y, s_von, s_pt);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [24:0] e;
    for (int it = 0; it < 4; it++) begin
      repeat ($urandom_range(800, 1)) @(posedge clk);
      #($urandom_range(9, 1));
      rst_f = 1'b0;
      #1;
      checks++;
      if (act_f !== RST_VEC) begin
        fails++; $display("FAIL async_reset_full: got %h expected %h", act_f, RST_VEC);
      end
      repeat ($urandom_range(3, 1)) @(posedge clk);
      @(negedge clk);
      rst_f = 1'b1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        e = m_full(n_f);
        checks++;
        if (act_f !== e) begin
          fails++; $display("FAIL restart_full n=%0d: got %h expected %h", n_f, act_f, e);
        end
      end
    end
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(2 * SFRAME, 1)) @(posedge clk);
      #($urandom_range(9, 1));
      rst_s = 1'b0;
      #1;
      checks++;
      if (act_s !== RST_VEC) begin
        fails++; $display("FAIL async_reset_small: got %h expected %h", act_s, RST_VEC);
      end
      repeat ($urandom_range(3, 1)) @(posedge clk);
      @(negedge clk);
      rst_s = 1'b1;
      for (int i = 0; i < SFRAME; i++) begin
        @(negedge clk);
        e = m_small(n_s);
        checks++;
        if (act_s !== e) begin
          fails++; $display("FAIL restart_small n=%0d: got %h expected %h", n_s, act_s, e);
        end
      end
    end
  endtask

`ifdef VGA_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int pulses = 0;
    rst_s = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (s_fc !== 8'd0) begin
      fails++; $display("FAIL fc_reset: got %0d expected 0", s_fc);
    end
    rst_s = 1'b1;
    for (int i = 0; i < 257 * SFRAME; i++) begin
      @(negedge clk);
      if (s_rt) begin
        pulses++;
        checks++;
        if (s_fc !== fc_s) begin
          fails++; $display("FAIL fc_model pulse=%0d: got %0d expected %0d", pulses, s_fc, fc_s);
        end
        @(negedge clk);
        checks++;
        if (s_fc !== 8'(pulses)) begin
          fails++; $display("FAIL fc_after pulse=%0d: got %0d expected %0d", pulses, s_fc, pulses % 256);
        end
      end
    end
    checks++;
    if (pulses < 256) begin
      fails++; $display("FAIL fc_pulses: got %0d expected at least 256", pulses);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_wrap();
    test_reset_mid();
`ifdef VGA_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
